// File: rtl/midi_voice_allocator.sv
// -----------------------------------------------------------------------------
// midi_voice_allocator
//
// Polyphony controller between the MIDI byte-breakout stage and the synth voice
// bank. It takes completed MIDI messages (status + two data bytes) and maps
// note-on / note-off / all-notes-off events onto N_VOICES voice slots.
// A note-on goes to the voice already holding that note (retrigger). Failing
// that it goes to the lowest free voice. Failing that it steals a voice in
// round-robin order.
//
// Ports:
//   sys_clk     in   system clock, single domain
//   rst_n       in   synchronous active-low reset
//   MIDI_CMD    in   status byte of the completed message
//   MIDI_DAT_0  in   data byte 0 (note / controller number)
//   MIDI_DAT_1  in   data byte 1 (velocity / controller value)
//   DATA_READY  in   one-cycle strobe, all three bytes valid
//   VOICE_NOTE  out  packed 7-bit note per voice, voice v at [7v+6:7v]
//   VOICE_VEL   out  packed 7-bit velocity per voice, same packing
//   VOICE_GATE  out  per-voice gate (1 = held)
//   VOICE_TRIG  out  per-voice one-cycle (re)start pulse
//   BUSY        out  high while an event is in flight
//   EVENT_DROP  out  pulses when DATA_READY arrives while BUSY
// -----------------------------------------------------------------------------
module midi_voice_allocator #(
    parameter int       N_VOICES = 4,
    parameter int       BYTE_W   = 8,
    parameter bit [3:0] MIDI_CH  = 4'd0,
    parameter bit       OMNI     = 1'b0
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [BYTE_W-1:0]       MIDI_CMD,
    input  logic [BYTE_W-1:0]       MIDI_DAT_0,
    input  logic [BYTE_W-1:0]       MIDI_DAT_1,
    input  logic                    DATA_READY,
    output logic [7*N_VOICES-1:0]   VOICE_NOTE,
    output logic [7*N_VOICES-1:0]   VOICE_VEL,
    output logic [N_VOICES-1:0]     VOICE_GATE,
    output logic [N_VOICES-1:0]     VOICE_TRIG,
    output logic                    BUSY,
    output logic                    EVENT_DROP
);

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_SCAN,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        OP_ON,
        OP_OFF,
        OP_ALLOFF
    } op_t;

    state_t state, state_nxt;

    // Latched message. Data bytes are cut to 7 bits when they are captured.
    logic [7:0]       cmd_q;
    logic [6:0]       d0_q;
    logic [6:0]       d1_q;
    op_t              op_q;

    // Scan bookkeeping.
    logic [IDX_W-1:0] scan_idx;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] steal_ptr;

    // Voice state.
    logic [6:0]          note_q [N_VOICES];
    logic [6:0]          vel_q  [N_VOICES];
    logic [N_VOICES-1:0] gate_q;
    logic [N_VOICES-1:0] trig_q;

    // Decode results (combinational, used in DECODE only).
    logic dec_ok;
    op_t  dec_op;

    // ON target selection (combinational, used in COMMIT only).
    logic [IDX_W-1:0] target;
    logic             is_steal;

    // -------------------------------------------------------------------------
    // Message decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        dec_ok = 1'b0;
        dec_op = OP_ON;
        if (OMNI || (cmd_q[3:0] == MIDI_CH)) begin
            case (cmd_q[7:4])
                4'h9: begin
                    dec_ok = 1'b1;
                    // Note-on with zero velocity is a note-off by MIDI convention.
                    dec_op = (d1_q != 7'd0) ? OP_ON : OP_OFF;
                end
                4'h8: begin
                    dec_ok = 1'b1;
                    dec_op = OP_OFF;
                end
                4'hB: begin
                    if (d0_q == 7'h7B) begin
                        dec_ok = 1'b1;
                        dec_op = OP_ALLOFF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        target   = steal_ptr;
        is_steal = 1'b0;
        if (match_found) begin
            target = match_idx;
        end else if (free_found) begin
            target = free_idx;
        end else begin
            is_steal = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (DATA_READY) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!dec_ok)                 state_nxt = S_IDLE;
                else if (dec_op == OP_ALLOFF) state_nxt = S_COMMIT;
                else                          state_nxt = S_SCAN;
            end
            S_SCAN:   if (scan_idx == LAST_IDX) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            d0_q        <= '0;
            d1_q        <= '0;
            op_q        <= OP_ON;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            steal_ptr   <= '0;
            gate_q      <= '0;
            trig_q      <= '0;
            // NOTE: the note/velocity store is reset as well, because it drives
            // outputs directly and those must read 0 after reset.
            for (int v = 0; v < N_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments, so every
            // read in this block sees the value from before this edge.
            trig_q <= '0;
            case (state)
                S_IDLE: begin
                    if (DATA_READY) begin
                        cmd_q <= MIDI_CMD[7:0];
                        d0_q  <= MIDI_DAT_0[6:0];
                        d1_q  <= MIDI_DAT_1[6:0];
                    end
                end
                S_DECODE: begin
                    op_q        <= dec_op;
                    scan_idx    <= '0;
                    match_found <= 1'b0;
                    match_idx   <= '0;
                    free_found  <= 1'b0;
                    free_idx    <= '0;
                end
                S_SCAN: begin
                    // Only the first hit of each kind is kept. Scanning upwards
                    // means the recorded index is the lowest one.
                    if (!match_found && gate_q[scan_idx] && (note_q[scan_idx] == d0_q)) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !gate_q[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                S_COMMIT: begin
                    case (op_q)
                        OP_ON: begin
                            note_q[target] <= d0_q;
                            vel_q[target]  <= d1_q;
                            gate_q[target] <= 1'b1;
                            trig_q[target] <= 1'b1;
                            if (is_steal) begin
                                steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + 1'b1;
                            end
                        end
                        OP_OFF: begin
                            // Note and velocity stay put so the envelope can
                            // still use them during release.
                            if (match_found) gate_q[match_idx] <= 1'b0;
                        end
                        OP_ALLOFF: gate_q <= '0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    for (genvar v = 0; v < N_VOICES; v++) begin : g_pack
        assign VOICE_NOTE[7*v +: 7] = note_q[v];
        assign VOICE_VEL[7*v +: 7]  = vel_q[v];
    end

    assign VOICE_GATE = gate_q;
    assign VOICE_TRIG = trig_q;
    assign BUSY       = (state != S_IDLE);
    // The COMMIT cycle still counts as busy, so a strobe in that cycle drops.
    assign EVENT_DROP = DATA_READY && (state != S_IDLE);

endmodule

// File: tb/tb_midi_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_midi_voice_allocator
//
// Directed testbench for midi_voice_allocator with N_VOICES=4, MIDI_CH=0 and
// OMNI=0. Expected values are hand-computed constants.
// Inputs are driven and outputs are sampled on the falling edge of sys_clk.
// -----------------------------------------------------------------------------
module tb_midi_voice_allocator;

    localparam int N = 4;

    logic            sys_clk;
    logic            rst_n;
    logic [7:0]      MIDI_CMD;
    logic [7:0]      MIDI_DAT_0;
    logic [7:0]      MIDI_DAT_1;
    logic            DATA_READY;
    logic [7*N-1:0]  VOICE_NOTE;
    logic [7*N-1:0]  VOICE_VEL;
    logic [N-1:0]    VOICE_GATE;
    logic [N-1:0]    VOICE_TRIG;
    logic            BUSY;
    logic            EVENT_DROP;

    int n_vec;
    int n_bad;

    midi_voice_allocator #(
        .N_VOICES (N),
        .BYTE_W   (8),
        .MIDI_CH  (4'd0),
        .OMNI     (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .MIDI_CMD   (MIDI_CMD),
        .MIDI_DAT_0 (MIDI_DAT_0),
        .MIDI_DAT_1 (MIDI_DAT_1),
        .DATA_READY (DATA_READY),
        .VOICE_NOTE (VOICE_NOTE),
        .VOICE_VEL  (VOICE_VEL),
        .VOICE_GATE (VOICE_GATE),
        .VOICE_TRIG (VOICE_TRIG),
        .BUSY       (BUSY),
        .EVENT_DROP (EVENT_DROP)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int v);
        return VOICE_NOTE[7*v +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int v);
        return VOICE_VEL[7*v +: 7];
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    // Strobes one message in cycle 0 and returns at the negedge of cycle 1.
    task automatic apply(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge sys_clk);
        MIDI_CMD   = c;
        MIDI_DAT_0 = d0;
        MIDI_DAT_1 = d1;
        DATA_READY = 1'b1;
        @(negedge sys_clk);
        DATA_READY = 1'b0;
    endtask

    // Applies a message and returns at the negedge of cycle 'at'.
    task automatic evt(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1, input int at);
        apply(c, d0, d1);
        repeat (at - 1) @(negedge sys_clk);
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        MIDI_CMD   = '0;
        MIDI_DAT_0 = '0;
        MIDI_DAT_1 = '0;
        DATA_READY = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_gate", VOICE_GATE, 0);
        check("rst_note", VOICE_NOTE, 0);
        check("rst_vel",  VOICE_VEL,  0);
        check("rst_trig", VOICE_TRIG, 0);
        check("rst_busy", BUSY, 0);
        check("rst_drop", EVENT_DROP, 0);

        // ---- single note-on: latency and BUSY window ----
        apply(8'h90, 8'h3C, 8'h64);
        check("on1_busy_c1", BUSY, 1);
        for (int c = 2; c <= N + 2; c++) begin
            @(negedge sys_clk);
            check($sformatf("on1_busy_c%0d", c), BUSY, 1);
            check($sformatf("on1_gate_c%0d", c), VOICE_GATE, 0);
        end
        @(negedge sys_clk);   // cycle 7
        check("on1_busy_c7", BUSY, 0);
        check("on1_gate", VOICE_GATE, 4'b0001);
        check("on1_note0", note_of(0), 7'h3C);
        check("on1_vel0", vel_of(0), 7'h64);
        check("on1_trig", VOICE_TRIG, 4'b0001);
        @(negedge sys_clk);
        check("on1_trig_off", VOICE_TRIG, 0);

        // ---- fill all voices, then steal round-robin ----
        do_reset();
        evt(8'h90, 8'h3C, 8'h10, N + 3);
        check("fill0_gate", VOICE_GATE, 4'b0001);
        evt(8'h90, 8'h40, 8'h11, N + 3);
        check("fill1_gate", VOICE_GATE, 4'b0011);
        check("fill1_trig", VOICE_TRIG, 4'b0010);
        evt(8'h90, 8'h43, 8'h12, N + 3);
        check("fill2_gate", VOICE_GATE, 4'b0111);
        check("fill2_trig", VOICE_TRIG, 4'b0100);
        evt(8'h90, 8'h48, 8'h13, N + 3);
        check("fill3_gate", VOICE_GATE, 4'b1111);
        check("fill3_trig", VOICE_TRIG, 4'b1000);
        check("fill3_note3", note_of(3), 7'h48);
        evt(8'h90, 8'h4C, 8'h14, N + 3);
        check("steal0_trig", VOICE_TRIG, 4'b0001);
        check("steal0_note0", note_of(0), 7'h4C);
        check("steal0_vel0", vel_of(0), 7'h14);
        check("steal0_note1", note_of(1), 7'h40);
        check("steal0_gate", VOICE_GATE, 4'b1111);
        evt(8'h90, 8'h4F, 8'h15, N + 3);
        check("steal1_trig", VOICE_TRIG, 4'b0010);
        check("steal1_note1", note_of(1), 7'h4F);
        check("steal1_note0", note_of(0), 7'h4C);

        // ---- note-off variants ----
        do_reset();
        evt(8'h90, 8'h3C, 8'h64, N + 3);
        evt(8'h90, 8'h40, 8'h50, N + 3);
        check("off_pre_gate", VOICE_GATE, 4'b0011);
        evt(8'h80, 8'h3C, 8'h00, N + 3);
        check("off8_gate", VOICE_GATE, 4'b0010);
        check("off8_note0", note_of(0), 7'h3C);
        check("off8_vel0", vel_of(0), 7'h64);
        check("off8_trig", VOICE_TRIG, 0);
        evt(8'h90, 8'h40, 8'h00, N + 3);
        check("off9v0_gate", VOICE_GATE, 4'b0000);
        check("off9v0_note1", note_of(1), 7'h40);
        evt(8'h80, 8'h50, 8'h00, N + 3);
        check("offnm_gate", VOICE_GATE, 4'b0000);
        check("offnm_note", VOICE_NOTE, {7'h00, 7'h00, 7'h40, 7'h3C});

        // ---- retrigger, then all-notes-off ----
        do_reset();
        evt(8'h90, 8'h3C, 8'h64, N + 3);
        evt(8'h90, 8'h40, 8'h50, N + 3);
        evt(8'h90, 8'h3C, 8'h20, N + 3);
        check("retrig_trig", VOICE_TRIG, 4'b0001);
        check("retrig_vel0", vel_of(0), 7'h20);
        check("retrig_gate", VOICE_GATE, 4'b0011);
        // Data bytes with bit 7 set must be masked: 0xBC -> 0x3C, 0xC0 -> 0x40.
        evt(8'h90, 8'hBC, 8'hC0, N + 3);
        check("mask_trig", VOICE_TRIG, 4'b0001);
        check("mask_vel0", vel_of(0), 7'h40);
        check("mask_gate", VOICE_GATE, 4'b0011);
        apply(8'hB0, 8'h7B, 8'h00);
        check("alloff_busy_c1", BUSY, 1);
        @(negedge sys_clk);   // cycle 2 = COMMIT
        check("alloff_busy_c2", BUSY, 1);
        check("alloff_gate_c2", VOICE_GATE, 4'b0011);
        @(negedge sys_clk);   // cycle 3
        check("alloff_gate_c3", VOICE_GATE, 4'b0000);
        check("alloff_trig", VOICE_TRIG, 0);
        check("alloff_busy_c3", BUSY, 0);
        check("alloff_note0", note_of(0), 7'h3C);

        // ---- wrong channel and unhandled controller are ignored ----
        do_reset();
        apply(8'h91, 8'h3C, 8'h64);
        check("ch_busy_c1", BUSY, 1);
        @(negedge sys_clk);
        check("ch_busy_c2", BUSY, 0);
        repeat (N + 2) @(negedge sys_clk);
        check("ch_gate", VOICE_GATE, 0);
        check("ch_note", VOICE_NOTE, 0);
        evt(8'hB0, 8'h07, 8'h7F, 2);
        check("cc_busy_c2", BUSY, 0);
        check("cc_gate", VOICE_GATE, 0);

        // ---- collision during SCAN and during COMMIT ----
        apply(8'h90, 8'h3C, 8'h64);
        @(negedge sys_clk);                 // cycle 2
        @(negedge sys_clk);                 // cycle 3
        MIDI_CMD   = 8'h90;
        MIDI_DAT_0 = 8'h50;
        MIDI_DAT_1 = 8'h7F;
        DATA_READY = 1'b1;
        #1;
        check("drop_scan_pulse", EVENT_DROP, 1);
        @(negedge sys_clk);                 // cycle 4
        DATA_READY = 1'b0;
        #1;
        check("drop_scan_clear", EVENT_DROP, 0);
        repeat (N - 1) @(negedge sys_clk);  // cycle 7
        check("drop_scan_gate", VOICE_GATE, 4'b0001);
        check("drop_scan_note0", note_of(0), 7'h3C);
        check("drop_scan_vel0", vel_of(0), 7'h64);
        check("drop_scan_trig", VOICE_TRIG, 4'b0001);

        apply(8'h90, 8'h40, 8'h30);
        repeat (N + 1) @(negedge sys_clk);  // cycle 6 = COMMIT
        MIDI_CMD   = 8'h90;
        MIDI_DAT_0 = 8'h45;
        MIDI_DAT_1 = 8'h70;
        DATA_READY = 1'b1;
        #1;
        check("drop_commit_pulse", EVENT_DROP, 1);
        @(negedge sys_clk);                 // cycle 7
        DATA_READY = 1'b0;
        repeat (N + 4) @(negedge sys_clk);
        check("drop_commit_gate", VOICE_GATE, 4'b0011);
        check("drop_commit_note1", note_of(1), 7'h40);
        check("drop_commit_busy", BUSY, 0);

        // ---- reset in the middle of a note-on ----
        apply(8'h90, 8'h43, 8'h22);
        @(negedge sys_clk);                 // cycle 2 (SCAN)
        rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_gate", VOICE_GATE, 0);
        check("midrst_note", VOICE_NOTE, 0);
        check("midrst_vel", VOICE_VEL, 0);
        check("midrst_trig", VOICE_TRIG, 0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("midrst_busy", BUSY, 0);
        for (int c = 0; c < N + 2; c++) begin
            @(negedge sys_clk);
            check($sformatf("midrst_notrig%0d", c), VOICE_TRIG, 0);
        end
        evt(8'h90, 8'h48, 8'h33, N + 3);
        check("post_rst_trig", VOICE_TRIG, 4'b0001);
        check("post_rst_note0", note_of(0), 7'h48);
        check("post_rst_gate", VOICE_GATE, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
